divider_8bit: RTL

DIVIDER_8BIT -- requirements
Module: divider_8bit

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/sub_nbit.sv | 43 ++++
 rtl/divider_8bit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the divider slice.
//   WIDTH_DEF    - default operand/result width for divider_8bit
//   div_state_e  - divider FSM states (IDLE, RUN, DONE)
//   cla4()       - 4-bit carry-lookahead adder cell, returns {carry_out, sum}
package cpu_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/sub_nbit.sv
// sub_nbit: unsigned N-bit subtractor a - b built from 4-bit lookahead cells
// (a + ~b + 1), ripple-carried between cells.
//   a, b   - N-bit operands
//   diff   - N-bit two's-complement difference
//   borrow - 1 when b > a
import cpu_pkg::*;

module sub_nbit #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int unsigned NB = (N + 3) / 4;
  localparam int unsigned NP = NB * 4;

  logic [NP-1:0] a_p;
  logic [NP-1:0] bn_p;
  logic [NP-1:0] s_p;
  logic [NB:0]   c;

  // Zero-extend both operands before inverting b: the padded lanes of ~b are
  // all ones, so the carry passes through them unchanged to c[NB].
  assign a_p  = NP'(a);
  assign bn_p = ~(NP'(b));
  assign c[0] = 1'b1;

  for (genvar i = 0; i < NB; i++) begin : g_cla
    assign {c[i+1], s_p[4*i +: 4]} = cla4(a_p[4*i +: 4], bn_p[4*i +: 4], c[i]);
  end

  if (NP > N) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^s_p[NP-1:N];
  end

  assign diff   = s_p[N-1:0];
  assign borrow = ~c[NB];

endmodule

// File: rtl/divider_8bit.sv
// divider_8bit: multi-cycle restoring unsigned divider, one quotient bit per
// clock, MSB first.
//   clk, rst_n           - clock, asynchronous active-low reset
//   start                - request, accepted when busy=0 (IDLE or DONE)
//   dividend, divisor    - operands, captured on the accepting edge
//   busy                 - high while iterating
//   done                 - one-cycle pulse, results valid
//   quotient, remainder  - last result, held until the next accepting edge
//   div_zero             - last operation had divisor=0 (fast path only)
// Build option: DIVIDER_ZERO_CHECK_EN enables the zero-divisor fast path
// (IDLE/DONE -> DONE in one edge). Without it a zero divisor runs the full
// iteration and div_zero is tied low.
import cpu_pkg::*;

module divider_8bit #(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;
  logic             accept;
  logic             zero_fast;
  logic             run_last;
  logic             unused_diff_msb;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};

  sub_nbit #(.N(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // When the trial subtraction keeps its result the difference is below the
  // divisor, so its top bit is always zero; on restore, shifted < divisor.
  assign unused_diff_msb = diff[WIDTH];
  assign rem_step = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dvd_step = {dvd_q[WIDTH-2:0], ~borrow};

  assign accept   = start && (state_q != ST_RUN);
  assign run_last = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH - 1));

`ifdef DIVIDER_ZERO_CHECK_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept && zero_fast) begin
          state_d = ST_DONE;
          quo_d   = '1;
          rmd_d   = dividend;
        end else if (accept) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = dividend;
          dvs_d   = divisor;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        rem_d = rem_step;
        dvd_d = dvd_step;
        if (run_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          quo_d   = dvd_step;
          rmd_d   = rem_step;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

`ifdef DIVIDER_ZERO_CHECK_EN
  logic dz_q;

  // Set by the fast path, cleared only when a full iteration completes, so it
  // holds across RUN like the other results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_q <= 1'b0;
    end else if (accept && zero_fast) begin
      dz_q <= 1'b1;
    end else if (run_last) begin
      dz_q <= 1'b0;
    end
  end

  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule
